// File: rtl/muldiv_pkg.sv
// Shared opcode and state types for the multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101,
      MD_NOP6  = 3'b110,
      MD_NOP7  = 3'b111
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } md_state_t;

   function automatic logic md_is_signed(md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic md_is_div(md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mips_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   import muldiv_pkg::*;

   logic             in_valid;
   logic             in_ready;
   md_op_t           op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport slave (
      input  in_valid, op, src_a, src_b,
      output in_ready, busy, done, div_zero, hi, lo
   );

   modport master (
      output in_valid, op, src_a, src_b,
      input  in_ready, busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/mips_div_iter.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module mips_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           q_bit;

   // rem < divisor keeps a non-negative difference below 2^WIDTH, so bit WIDTH is the borrow
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      diff    = shifted - {1'b0, divisor_i};
      q_bit   = ~diff[WIDTH];
      rem_o   = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_o   = {quo_i[WIDTH-2:0], q_bit};
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU in a single cycle.
module mips_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   mips_muldiv_unit_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   md_state_t          state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               is_div_q;
   logic               neg_res_q;
   logic               neg_rem_q;
   logic               busy_q;
   logic               done_q;
   logic               dz_q;

   logic               sgn_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   div_quo;

   mips_div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
      .quo_i     (acc_q[WIDTH-1:0]),
      .divisor_i (opnd_q),
      .rem_o     (div_rem),
      .quo_o     (div_quo)
   );

   // Both datapaths iterate on magnitudes; signs are reapplied in FIX
   always_comb begin
      sgn_op = md_is_signed(bus.op);
      a_neg  = sgn_op & bus.src_a[WIDTH-1];
      b_neg  = sgn_op & bus.src_b[WIDTH-1];
      mag_a  = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
      mag_b  = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
   end

   // Shift-add: the low half holds the remaining multiplier bits, the high half the partial sum
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_d   = is_div_q ? {div_rem, div_quo} : {mul_sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
      quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         a_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dz_q <= 1'b0;
                  case (bus.op)
                     MD_MTHI: begin
                        hi_q   <= bus.src_a;
                        done_q <= 1'b1;
                     end
                     MD_MTLO: begin
                        lo_q   <= bus.src_a;
                        done_q <= 1'b1;
                     end
                     MD_NOP6, MD_NOP7: begin
                        done_q <= 1'b1;
                     end
                     default: begin
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        a_q       <= bus.src_a;
                        is_div_q  <= md_is_div(bus.op);
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (md_is_div(bus.op)) begin
                           opnd_q  <= mag_b;
                           acc_q   <= {{WIDTH{1'b0}}, mag_a};
                           state_q <= RUN;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                           acc_q   <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                           state_q <= FIX;
`else
                           opnd_q  <= mag_a;
                           acc_q   <= {{WIDTH{1'b0}}, mag_b};
                           state_q <= RUN;
`endif
                        end
                     end
                  endcase
               end
            end
            RUN: begin
               acc_q <= acc_d;
               if (cnt_q == LAST_STEP) begin
                  cnt_q   <= '0;
                  state_q <= FIX;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            FIX: begin
               // Divide by zero bypasses the datapath: LO all ones, HI the raw dividend
               if (is_div_q && (opnd_q == '0)) begin
                  lo_q <= '1;
                  hi_q <= a_q;
                  dz_q <= 1'b1;
               end else if (is_div_q) begin
                  lo_q <= quo_fix;
                  hi_q <= rem_fix;
               end else begin
                  lo_q <= prod_fix[WIDTH-1:0];
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready = ~busy_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: timeline reference model plus directed literal cases and random traffic.
module tb_mips_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mips_muldiv_unit_if #(.WIDTH(W)) mif ();

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (mif)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   // Reference state: architectural HI/LO plus a countdown to the pending result
   logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
   bit m_busy, m_done, m_dz, p_dz;
   int m_pend;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic void ref_md(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output bit dz);
      longint sp;
      logic [63:0] up;
      int sa, sb;
      dz = 1'b0; h = '0; l = '0;
      sa = a; sb = b;
      case (op)
         MD_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {h, l} = sp;
         end
         MD_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            {h, l} = up;
         end
         MD_DIV, MD_DIVU: begin
            if (b == 0) begin
               l = '1; h = a; dz = 1'b1;
            end else if (op == MD_DIVU) begin
               l = a / b; h = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               l = a; h = '0;
            end else begin
               l = sa / sb; h = sa % sb;
            end
         end
         default: ;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0; m_pend = 0;
      end else begin
         m_done = 0;
         if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1; m_busy = 0;
            end
         end else if (mif.in_valid) begin
            m_dz = 0;
            case (mif.op)
               MD_MTHI: begin m_hi = mif.src_a; m_done = 1; end
               MD_MTLO: begin m_lo = mif.src_a; m_done = 1; end
               MD_NOP6, MD_NOP7: m_done = 1;
               default: begin
                  ref_md(mif.op, mif.src_a, mif.src_b, p_hi, p_lo, p_dz);
                  m_busy = 1;
                  m_pend = md_is_div(mif.op) ? DIV_LAT : MUL_LAT;
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("busy", mif.busy, m_busy);
         chk("in_ready", mif.in_ready, !m_busy);
         chk("done", mif.done, m_done);
         chk("div_zero", mif.div_zero, m_dz);
         chk("hi", mif.hi, m_hi);
         chk("lo", mif.lo, m_lo);
      end
   end

   task automatic issue(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk); #1;
      mif.in_valid = 1'b1; mif.op = op; mif.src_a = a; mif.src_b = b;
      @(negedge clk); #1;
      mif.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int ready_cnt);
      lat = -1; ready_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (mif.done === 1'b1) begin
            lat = i;
            break;
         end
         if (mif.in_ready === 1'b1) ready_cnt++;
         @(negedge clk); #1;
      end
   endtask

   task automatic run_op(input string nm, input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input int elat);
      int lat, rdy;
      issue(op, a, b);
      wait_done(lat, rdy);
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_ready_low"}, rdy, 0);
      chk({nm, "_hi"}, mif.hi, eh);
      chk({nm, "_lo"}, mif.lo, el);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 15));
         4: return 32'h7FFF_FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      logic [W-1:0] th, tl;
      bit tdz;
      int lat, rdy, extra;

      mif.in_valid = 1'b0; mif.op = MD_MULT; mif.src_a = '0; mif.src_b = '0;

      // Pin the reference model against hand-computed values
      ref_md(MD_MULT, 32'hFFFF_FFFD, 32'd7, th, tl, tdz);
      chk("model_mult", {th, tl}, 64'hFFFF_FFFF_FFFF_FFEB);
      ref_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, th, tl, tdz);
      chk("model_div", {th, tl}, 64'hFFFF_FFFF_FFFF_FFFD);

      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("reset_hi", mif.hi, 0);
      chk("reset_lo", mif.lo, 0);
      chk("reset_busy", mif.busy, 0);
      chk("reset_ready", mif.in_ready, 1);
      chk("reset_done", mif.done, 0);
      check_en = 1'b1;
      #1 reset_n = 1'b1;

      run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
      run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
      run_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, DIV_LAT);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
      run_op("divu_zero", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT);
      chk("divu_zero_flag", mif.div_zero, 1);

      // MTHI then MTLO on consecutive cycles
      @(negedge clk); #1;
      mif.in_valid = 1'b1; mif.op = MD_MTHI; mif.src_a = 32'h1234;
      @(negedge clk); #1;
      chk("mthi_done", mif.done, 1);
      chk("mthi_hi", mif.hi, 32'h1234);
      mif.op = MD_MTLO; mif.src_a = 32'h5678;
      @(negedge clk); #1;
      mif.in_valid = 1'b0;
      chk("mtlo_done", mif.done, 1);
      chk("mtlo_lo", mif.lo, 32'h5678);
      chk("mtlo_hi", mif.hi, 32'h1234);

      // A request presented while busy must be dropped
      issue(MD_DIVU, 32'd7, 32'd2);
      repeat (3) @(negedge clk);
      #1 mif.in_valid = 1'b1; mif.op = MD_DIV; mif.src_a = 32'd100; mif.src_b = 32'd3;
      @(negedge clk); #1 mif.in_valid = 1'b0;
      wait_done(lat, rdy);
      chk("busy_ignore_seen", lat >= 0, 1);
      chk("busy_ignore_lo", mif.lo, 32'd3);
      chk("busy_ignore_hi", mif.hi, 32'd1);
      extra = 0;
      repeat (40) begin
         @(negedge clk); #1;
         if (mif.done === 1'b1) extra++;
      end
      chk("busy_ignore_no_extra", extra, 0);

      // Reset part-way through a MULTU
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(negedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk); #1;
      chk("abort_hi", mif.hi, 0);
      chk("abort_lo", mif.lo, 0);
      chk("abort_busy", mif.busy, 0);
      reset_n = 1'b1;
      extra = 0;
      repeat (40) begin
         @(negedge clk); #1;
         if (mif.done === 1'b1) extra++;
      end
      chk("abort_no_done", extra, 0);

      // Random traffic, including requests while busy and back-to-back accepts
      for (int c = 0; c < 12000; c++) begin
         @(negedge clk); #1;
         mif.in_valid = ($urandom_range(0, 3) != 0);
         mif.op = md_op_t'(3'($urandom_range(0, 7)));
         mif.src_a = pick_operand();
         mif.src_b = pick_operand();
      end
      @(negedge clk); #1 mif.in_valid = 1'b0;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
